// File: rtl/calc_cpu_sequencer.sv
// Sequences one calculator operation: writes operands/opcode into the mailbox,
// runs the CPU until it fetches the halt word, then reads the result back.
module calc_cpu_sequencer #(
  parameter logic [31:0] ADDR_A     = 32'h0000_0100,
  parameter logic [31:0] ADDR_OP    = 32'h0000_0104,
  parameter logic [31:0] ADDR_B     = 32'h0000_0108,
  parameter logic [31:0] ADDR_RES   = 32'h0000_010C,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic        hz100,
  input  logic        nrst,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  op_code,
  input  logic        mem_busy,
  input  logic [31:0] instruction,
  input  logic [31:0] ram_value,
  output logic [31:0] address_out,
  output logic [31:0] data_out,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic        cpu_enable,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle, StWrA, StWrOp, StWrB, StRun, StRdRes, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       opa_q, opa_d;
  logic [31:0]       opb_q, opb_d;
  logic [3:0]        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;
  logic              start_acc;

  // A start is only honoured from a resting state, and clear always wins.
  assign start_acc = start && !clear &&
                     (state_q == StIdle || state_q == StDone || state_q == StErr);

  // State and datapath registers.
  always_ff @(posedge hz100 or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: if (start) state_d = StWrA;
        StWrA:   if (!mem_busy) state_d = StWrOp;
        StWrOp:  if (!mem_busy) state_d = StWrB;
        StWrB:   if (!mem_busy) state_d = StRun;
        StRun: begin
          // Halt wins over timeout when both happen in the same cycle.
          if (instruction == HALT_INSTR)      state_d = StRdRes;
          else if (cnt_q == CntW'(TIMEOUT - 1)) state_d = StErr;
        end
        StRdRes: if (!mem_busy) state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // Operand latching, RUN cycle counter and result capture.
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    cnt_d    = (state_q == StRun) ? cnt_q + CntW'(1) : '0;
    result_d = result_q;
    if (start_acc) begin
      opa_d = operand_a;
      opb_d = operand_b;
      op_d  = op_code;
    end
    if (clear) begin
      result_d = '0;
    end else if (state_q == StRdRes && !mem_busy) begin
      result_d = ram_value;
    end
  end

  // Moore output decode.
  always_comb begin
    address_out  = '0;
    data_out     = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    cpu_enable   = 1'b0;
    result_valid = 1'b0;
    timeout_err  = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      StWrA: begin
        mem_write_en = 1'b1;
        address_out  = ADDR_A;
        data_out     = opa_q;
        busy         = 1'b1;
      end
      StWrOp: begin
        mem_write_en = 1'b1;
        address_out  = ADDR_OP;
        data_out     = {28'b0, op_q};
        busy         = 1'b1;
      end
      StWrB: begin
        mem_write_en = 1'b1;
        address_out  = ADDR_B;
        data_out     = opb_q;
        busy         = 1'b1;
      end
      StRun: begin
        cpu_enable = 1'b1;
        busy       = 1'b1;
      end
      StRdRes: begin
        mem_read_en = 1'b1;
        address_out = ADDR_RES;
        busy        = 1'b1;
      end
      StDone:  result_valid = 1'b1;
      StErr:   timeout_err  = 1'b1;
      default: ;
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_calc_cpu_sequencer.sv
// Scoreboard bench for calc_cpu_sequencer: expected writes/results are queued
// when a start is driven and popped as the DUT performs them.
module tb_calc_cpu_sequencer;

  localparam logic [31:0] ADDR_A   = 32'h0000_0100;
  localparam logic [31:0] ADDR_OP  = 32'h0000_0104;
  localparam logic [31:0] ADDR_B   = 32'h0000_0108;
  localparam logic [31:0] ADDR_RES = 32'h0000_010C;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        hz100 = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [3:0]  op_code = '0;
  logic        mem_busy = 1'b0;
  logic [31:0] instruction = NOP;
  logic [31:0] ram_value = '0;
  logic [31:0] address_out, data_out, result;
  logic        mem_write_en, mem_read_en, cpu_enable, result_valid, busy, timeout_err;

  calc_cpu_sequencer dut (
    .hz100       (hz100),
    .nrst        (nrst),
    .start       (start),
    .clear       (clear),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_code     (op_code),
    .mem_busy    (mem_busy),
    .instruction (instruction),
    .ram_value   (ram_value),
    .address_out (address_out),
    .data_out    (data_out),
    .mem_write_en(mem_write_en),
    .mem_read_en (mem_read_en),
    .cpu_enable  (cpu_enable),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 hz100 = ~hz100;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] wq[$];
  logic [31:0] rq[$];

  int wr_cnt = 0, rd_cnt = 0, en_cnt = 0;
  int halt_at = 0, op_stall = 0, rd_stall = 0, run_cnt = 0;
  logic busy_force = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Environment: CPU instruction stream and memory backpressure.
  always @(posedge hz100) begin
    #2;
    if (cpu_enable) run_cnt++;
    else run_cnt = 0;
    instruction = (halt_at != 0 && run_cnt == halt_at) ? HALT : NOP;
    mem_busy = busy_force;
    if (mem_write_en && address_out == ADDR_OP && op_stall > 0) begin
      mem_busy = 1'b1;
      op_stall--;
    end
    if (mem_read_en && rd_stall > 0) begin
      mem_busy = 1'b1;
      rd_stall--;
    end
  end

  // Monitor: accepted accesses, hold-stability and result scoreboard.
  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  always @(negedge hz100) begin
    check_eq("onehot_en", 64'($countones({mem_write_en, mem_read_en, cpu_enable}) <= 1), 64'd1);
    if (mem_write_en && !mem_busy) begin
      wr_cnt++;
      check_eq("wr_expected", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) check_eq("wr_addr_data", {address_out, data_out}, wq.pop_front());
    end
    if (mem_read_en && !mem_busy) begin
      rd_cnt++;
      check_eq("rd_addr", 64'(address_out), 64'(ADDR_RES));
    end
    if ((mem_write_en || mem_read_en) && mem_busy) begin
      if (prev_stall) check_eq("hold_stable", {address_out, data_out}, {prev_addr, prev_data});
      prev_stall = 1'b1;
      prev_addr  = address_out;
      prev_data  = data_out;
    end else begin
      prev_stall = 1'b0;
    end
    if (cpu_enable) en_cnt++;
    if (result_valid && !prev_valid) begin
      check_eq("res_expected", 64'(rq.size() != 0), 64'd1);
      if (rq.size() != 0) check_eq("result", 64'(result), 64'(rq.pop_front()));
    end
    prev_valid = result_valid;
  end

  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input bit push_wr, input bit push_res, input logic [31:0] res);
    @(posedge hz100); #1;
    start = 1'b1;
    operand_a = a;
    operand_b = b;
    op_code = op;
    if (push_wr) begin
      wq.push_back({ADDR_A, a});
      wq.push_back({ADDR_OP, 28'b0, op});
      wq.push_back({ADDR_B, b});
    end
    if (push_res) rq.push_back(res);
    @(posedge hz100); #1;
    start = 1'b0;
    // Scramble inputs to show the in-flight sequence uses latched values.
    operand_a = ~a;
    operand_b = ~b;
    op_code = 4'h0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge hz100);
      n++;
      if (result_valid || timeout_err) break;
    end
    check_eq("wait_bound", 64'(result_valid || timeout_err), 64'd1);
  endtask

  task automatic wait_run(input int max);
    int n = 0;
    while (n < max && !cpu_enable) begin
      @(negedge hz100);
      n++;
    end
    check_eq("run_bound", 64'(cpu_enable), 64'd1);
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp_res);
    check_eq({tag, "_addr"}, 64'(address_out), 64'd0);
    check_eq({tag, "_data"}, 64'(data_out), 64'd0);
    check_eq({tag, "_en"}, 64'({mem_write_en, mem_read_en, cpu_enable}), 64'd0);
    check_eq({tag, "_flags"}, 64'({busy, result_valid, timeout_err}), 64'd0);
    check_eq({tag, "_res"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, w0, r0, e0;
    repeat (3) @(negedge hz100);
    check_idle("reset", 32'd0);
    @(posedge hz100); #1;
    nrst = 1'b1;
    repeat (2) @(negedge hz100);
    check_idle("post_reset", 32'd0);

    // Nominal add: 12 + 34 = 46, halt on the 10th RUN cycle.
    halt_at = 10; ram_value = 32'd46;
    w0 = wr_cnt; r0 = rd_cnt; e0 = en_cnt;
    do_start(32'd12, 32'd34, 4'd8, 1, 1, 32'd46);
    wait_done(100, n);
    check_eq("add_latency", 64'(n), 64'd15);
    check_eq("add_writes", 64'(wr_cnt - w0), 64'd3);
    check_eq("add_reads", 64'(rd_cnt - r0), 64'd1);
    check_eq("add_run_cycles", 64'(en_cnt - e0), 64'd10);
    check_eq("add_valid", 64'({result_valid, busy}), 64'b10);

    // Backpressure: 3 stalls in WR_OP, 2 in RD_RES.
    halt_at = 5; ram_value = 32'd93; op_stall = 3; rd_stall = 2;
    w0 = wr_cnt; r0 = rd_cnt;
    do_start(32'd100, 32'd7, 4'd4, 1, 1, 32'd93);
    check_eq("bp_valid_cleared", 64'(result_valid), 64'd0);
    wait_done(100, n);
    check_eq("bp_latency", 64'(n), 64'd15);
    check_eq("bp_writes", 64'(wr_cnt - w0), 64'd3);
    check_eq("bp_reads", 64'(rd_cnt - r0), 64'd1);
    check_eq("bp_stalls_used", 64'(op_stall + rd_stall), 64'd0);

    // Timeout: no halt ever.
    halt_at = 0; e0 = en_cnt;
    do_start(32'd1, 32'd2, 4'd2, 1, 0, 32'd0);
    wait_done(400, n);
    check_eq("to_latency", 64'(n), 64'd204);
    check_eq("to_run_cycles", 64'(en_cnt - e0), 64'd200);
    check_eq("to_flags", 64'({timeout_err, result_valid, busy}), 64'b100);
    check_eq("to_res_kept", 64'(result), 64'd93);

    // New start clears timeout_err; start during RUN is ignored (9*9 = 81).
    halt_at = 6; ram_value = 32'd81; w0 = wr_cnt; e0 = en_cnt;
    do_start(32'd9, 32'd9, 4'd2, 1, 1, 32'd81);
    check_eq("restart_clr_to", 64'({timeout_err, busy}), 64'b01);
    wait_run(20);
    do_start(32'd5, 32'd5, 4'd1, 0, 0, 32'd0);
    wait_done(100, n);
    check_eq("ign_res", 64'(result), 64'd81);
    check_eq("ign_writes", 64'(wr_cnt - w0), 64'd3);
    check_eq("ign_run_cycles", 64'(en_cnt - e0), 64'd6);

    // Clear in WR_B (memory busy so B never lands).
    do_start(32'd3, 32'd4, 4'd8, 1, 0, 32'd0);
    @(posedge hz100); #1;
    @(posedge hz100); #1;
    check_eq("abort_in_wrb", 64'(address_out), 64'(ADDR_B));
    clear = 1'b1; busy_force = 1'b1;
    @(posedge hz100); #1;
    clear = 1'b0; busy_force = 1'b0;
    check_idle("abort", 32'd0);
    check_eq("abort_b_pending", 64'(wq.size()), 64'd1);
    wq.delete();

    // Clear and start together in DONE.
    halt_at = 3; ram_value = 32'd42;
    do_start(32'd20, 32'd22, 4'd8, 1, 1, 32'd42);
    wait_done(100, n);
    check_eq("cs_res", 64'(result), 64'd42);
    @(posedge hz100); #1;
    clear = 1'b1; start = 1'b1; operand_a = 32'd1; operand_b = 32'd1; op_code = 4'd8;
    @(posedge hz100); #1;
    clear = 1'b0; start = 1'b0;
    check_idle("clr_start", 32'd0);
    repeat (2) @(negedge hz100);
    check_idle("clr_start_late", 32'd0);

    // Asynchronous reset mid-RUN.
    halt_at = 0;
    do_start(32'd7, 32'd8, 4'd8, 1, 0, 32'd0);
    wait_run(20);
    @(posedge hz100); #1;
    nrst = 1'b0;
    #1;
    check_idle("rst_mid", 32'd0);
    repeat (2) @(posedge hz100);
    #1;
    nrst = 1'b1;
    repeat (3) @(negedge hz100);
    check_idle("rst_release", 32'd0);
    check_eq("wq_empty", 64'(wq.size()), 64'd0);
    check_eq("rq_empty", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
